// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter for the single regfile write port.
// Define WB_BYPASS_EN to add a forwarding path from the registered write.
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_stall,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_rd_src,
    input  logic [XLEN-1:0] a_rd,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_rd_src,
    input  logic [XLEN-1:0] b_rd,
    output logic            reg_we,
    output logic [AW-1:0]   rd_src,
    output logic [XLEN-1:0] rd
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]   byp_rs1_src,
    input  logic [AW-1:0]   byp_rs2_src,
    output logic            byp_rs1_hit,
    output logic            byp_rs2_hit,
    output logic [XLEN-1:0] byp_rs1,
    output logic [XLEN-1:0] byp_rs2
`endif
);

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

    grant_e          last_grant_q, last_grant_d;
    logic            reg_we_q, reg_we_d;
    logic [AW-1:0]   rd_src_q, rd_src_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            a_hs, b_hs;

    // A wins unless B is also requesting and A had the previous grant
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst && !wb_stall) begin
            if (a_valid && (!b_valid || last_grant_q == GNT_B)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign a_hs = a_valid & a_ready;
    assign b_hs = b_valid & b_ready;

    // x0 writes are accepted and steer round-robin, but never reach the regfile
    always_comb begin
        last_grant_d = last_grant_q;
        reg_we_d     = 1'b0;
        rd_src_d     = rd_src_q;
        rd_d         = rd_q;
        if (a_hs) begin
            last_grant_d = GNT_A;
            reg_we_d     = (a_rd_src != '0);
            rd_src_d     = a_rd_src;
            rd_d         = a_rd;
        end else if (b_hs) begin
            last_grant_d = GNT_B;
            reg_we_d     = (b_rd_src != '0);
            rd_src_d     = b_rd_src;
            rd_d         = b_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_B;
            reg_we_q     <= 1'b0;
            rd_src_q     <= '0;
            rd_q         <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_we_q     <= reg_we_d;
            rd_src_q     <= rd_src_d;
            rd_q         <= rd_d;
        end
    end

    assign reg_we = reg_we_q;
    assign rd_src = rd_src_q;
    assign rd     = rd_q;

`ifdef WB_BYPASS_EN
    assign byp_rs1_hit = reg_we_q && (rd_src_q == byp_rs1_src) && (byp_rs1_src != '0);
    assign byp_rs2_hit = reg_we_q && (rd_src_q == byp_rs2_src) && (byp_rs2_src != '0);
    assign byp_rs1     = rd_q;
    assign byp_rs2     = rd_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios followed by
// constrained-random requests checked against a grant-rule model.
module tb_wb_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wb_stall = 1'b0;
    logic            a_valid = 1'b0;
    logic            a_ready;
    logic [AW-1:0]   a_rd_src = '0;
    logic [XLEN-1:0] a_rd = '0;
    logic            b_valid = 1'b0;
    logic            b_ready;
    logic [AW-1:0]   b_rd_src = '0;
    logic [XLEN-1:0] b_rd = '0;
    logic            reg_we;
    logic [AW-1:0]   rd_src;
    logic [XLEN-1:0] rd;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]   byp_rs1_src = '0;
    logic [AW-1:0]   byp_rs2_src = '0;
    logic            byp_rs1_hit, byp_rs2_hit;
    logic [XLEN-1:0] byp_rs1, byp_rs2;
`endif

    wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wb_stall(wb_stall),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_rd_src(a_rd_src), .a_rd(a_rd),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_rd_src(b_rd_src), .b_rd(b_rd),
        .reg_we(reg_we), .rd_src(rd_src), .rd(rd)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs1_src(byp_rs1_src), .byp_rs2_src(byp_rs2_src),
        .byp_rs1_hit(byp_rs1_hit), .byp_rs2_hit(byp_rs2_hit),
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   src;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;

    // Model state: who won last, and what the output port last showed
    bit              m_last_b = 1'b1;
    logic [AW-1:0]   m_src = '0;
    logic [XLEN-1:0] m_data = '0;

    task automatic cycle(input bit r, input bit s,
                         input bit av, input logic [AW-1:0] as,
                         input logic [XLEN-1:0] ad,
                         input bit bv, input logic [AW-1:0] bs,
                         input logic [XLEN-1:0] bd,
                         output bit acc_a, output bit acc_b);
        bit  ea, eb;
        wr_t e;
        @(negedge clk);
        rst = r; wb_stall = s;
        a_valid = av; a_rd_src = as; a_rd = ad;
        b_valid = bv; b_rd_src = bs; b_rd = bd;
`ifdef WB_BYPASS_EN
        byp_rs1_src = AW'($urandom_range(0, 7));
        byp_rs2_src = AW'($urandom_range(0, 7));
`endif
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (!r && !s) begin
            if (av && bv) begin
                if (m_last_b) ea = 1'b1;
                else          eb = 1'b1;
            end else begin
                ea = av;
                eb = bv;
            end
        end
        checks++;
        if (a_ready !== ea || b_ready !== eb) begin
            failures++;
            $display("FAIL ready t=%0t got a=%b b=%b want a=%b b=%b",
                     $time, a_ready, b_ready, ea, eb);
        end
        if (r) begin
            m_last_b = 1'b1; m_src = '0; m_data = '0;
            e.we = 1'b0;
        end else if (ea) begin
            m_last_b = 1'b0; m_src = as; m_data = ad;
            e.we = (as != '0);
        end else if (eb) begin
            m_last_b = 1'b1; m_src = bs; m_data = bd;
            e.we = (bs != '0);
        end else begin
            e.we = 1'b0;
        end
        e.src  = m_src;
        e.data = m_data;
        exp_q.push_back(e);
        mon_en = 1'b1;
        acc_a = ea;
        acc_b = eb;
    endtask

    // Monitor: one expected output-port state per clock edge
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow t=%0t got we=%b src=%0d rd=%h",
                             $time, reg_we, rd_src, rd);
                end else begin
                    e = exp_q.pop_front();
                    if ({reg_we, rd_src, rd} !== e) begin
                        failures++;
                        $display("FAIL wr_port t=%0t got we=%b src=%0d rd=%h want we=%b src=%0d rd=%h",
                                 $time, reg_we, rd_src, rd, e.we, e.src, e.data);
                    end
`ifdef WB_BYPASS_EN
                    checks++;
                    if (byp_rs1_hit !== (e.we && e.src == byp_rs1_src && byp_rs1_src != 0) ||
                        byp_rs2_hit !== (e.we && e.src == byp_rs2_src && byp_rs2_src != 0) ||
                        byp_rs1 !== e.data || byp_rs2 !== e.data) begin
                        failures++;
                        $display("FAIL bypass t=%0t got h1=%b h2=%b d=%h want d=%h",
                                 $time, byp_rs1_hit, byp_rs2_hit, byp_rs1, e.data);
                    end
`endif
                end
            end
        end
    end

    initial begin
        bit              ka, kb, pa, pb, r, s;
        logic [AW-1:0]   sa, sb;
        logic [XLEN-1:0] da, db;
        // reset with both requesting
        cycle(1, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, ka, kb);
        cycle(1, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, ka, kb);
        // contention: expect A,B,A,B
        repeat (4) cycle(0, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, ka, kb);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ka, kb);
        // single A
        cycle(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, ka, kb);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ka, kb);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ka, kb);
        // x0 drop on B, then tie goes to A
        cycle(0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h55, ka, kb);
        cycle(0, 0, 1, 5'd6, 32'h66, 1, 5'd8, 32'h88, ka, kb);
        cycle(0, 0, 0, 5'd0, 32'h0, 1, 5'd8, 32'h88, ka, kb);
        // stall holds A off for 3 cycles
        repeat (3) cycle(0, 1, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, ka, kb);
        cycle(0, 0, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, ka, kb);
        // idx 7 write for the bypass path
        cycle(0, 0, 1, 5'd7, 32'h1234, 0, 5'd0, 32'h0, ka, kb);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ka, kb);
        // write in flight at a reset edge is cancelled
        cycle(0, 0, 1, 5'd10, 32'hAA, 0, 5'd0, 32'h0, ka, kb);
        cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ka, kb);

        pa = 0; pb = 0;
        sa = '0; sb = '0; da = '0; db = '0;
        repeat (3000) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1;
                sa = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
                da = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1;
                sb = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
                db = $urandom;
            end
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 4) == 0);
            cycle(r, s, pa, sa, da, pb, sb, db, ka, kb);
            if (ka || r) pa = 0;
            if (kb || r) pb = 0;
        end
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ka, kb);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port (reg_we / rd_src / rd) between two writeback requesters: ALU/branch result (req A) and load unit (req B).
- Arbitrates between the two with valid/ready handshakes, drops writes to x0, and registers the winning write for one cycle before driving the regfile.
- Sits between the execute/memory stages and the regfile; sequences all architectural register updates.

Parameters:
- XLEN, 32, data width of the writeback value
- AW, 5, register index width (32 architectural registers)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_stall  in  1  freeze: when 1, no request is accepted
- a_valid  in  1  ALU writeback request valid
- a_ready  out  1  ALU request accepted this cycle
- a_rd_src  in  AW  ALU destination register index
- a_rd  in  XLEN  ALU writeback data
- b_valid  in  1  load writeback request valid
- b_ready  out  1  load request accepted this cycle
- b_rd_src  in  AW  load destination register index
- b_rd  in  XLEN  load writeback data
- reg_we  out  1  regfile write enable (`ENABLE when writing)
- rd_src  out  AW  regfile write index
- rd  out  XLEN  regfile write data

Behaviour:
- Reset (rst=1 at clk edge): reg_we=0, rd_src=0, rd=0, last_grant=B (ALU wins the first tie). a_ready/b_ready are 0 while rst=1.
- a_ready/b_ready are combinational from the current valids, wb_stall and last_grant; at most one is 1 per cycle.
- Grant rule (wb_stall=0):
  - only a_valid -> A
  - only b_valid -> B
  - both -> the requester not equal to last_grant (round-robin)
  - neither -> none
- wb_stall=1: both readies 0; last_grant holds; the output stage still presents/clears as below.
- last_grant updates to the winner only on a handshake (valid & ready).
- Output stage, registered, latency 1: a handshake at edge N drives rd_src/rd = winner's index/data from edge N, with reg_we=1 for exactly one cycle, unless the winner's index is 0.
- Index 0: the request is still accepted (ready=1) and counts for last_grant, but reg_we=0.
- No handshake: reg_we=0 next cycle; rd_src/rd hold their last values.
- The regfile write port accepts every cycle, so no backpressure from the output stage. Sustained throughput is 1 write/cycle. Under continuous dual requests, grants alternate A,B,A,B.
- Requesters must hold valid/rd_src/rd stable until ready. The arbiter does not check this.
- Reset mid-operation: a pending unaccepted request is not remembered. An output-stage write in flight at the reset edge is cancelled (reg_we=0 next cycle).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds inputs byp_rs1_src, byp_rs2_src (AW) and outputs byp_rs1_hit, byp_rs2_hit (1) and byp_rs1, byp_rs2 (XLEN).
  - byp_rsN_hit = reg_we & (rd_src == byp_rsN_src) & (byp_rsN_src != 0); byp_rsN = rd. Combinational.
  - Lets decode read a value one cycle before the regfile holds it.
- Undefined: the ports do not exist and there is no bypass logic. Core behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0; reg_we=0, rd_src=0, rd=0 after reset.
- Single A: a_valid=1, a_rd_src=5, a_rd=0xDEADBEEF for 1 cycle -> a_ready=1 that cycle; next cycle reg_we=1, rd_src=5, rd=0xDEADBEEF; following cycle reg_we=0.
- Contention: both valid for 4 cycles (A idx 1 / 0x11, B idx 2 / 0x22), requesters deassert after accept and reassert next cycle -> grants A,B,A,B; reg_we high 4 consecutive cycles with rd_src 1,2,1,2.
- x0 drop: b_valid=1, b_rd_src=0, b_rd=0x55 -> b_ready=1; next cycle reg_we=0; a subsequent tie is granted to A.
- Stall: wb_stall=1 for 3 cycles with a_valid=1 -> a_ready=0 throughout; on release, accept with reg_we one cycle later and last_grant unchanged during stall.
- (WB_BYPASS_EN) output stage writing idx 7 = 0x1234 while byp_rs1_src=7, byp_rs2_src=0 -> byp_rs1_hit=1, byp_rs1=0x1234, byp_rs2_hit=0.
